// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback datapath for the 5-stage RV32I core.
// Captures the memory stage results, formats load data by funct3, selects the
// register-file write value, issues the registered PC redirect, and counts
// retired instructions. Every output is derived from WB-side registers only.

module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_mem,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  mem_data_out,
    input  logic [XLEN-1:0]  alu_result_mem,
    input  logic [XLEN-1:0]  pc_plus_4_mem,
    input  logic [XLEN-1:0]  target_pc,
    input  logic [3:0]       control_word_mem,
    input  logic [4:0]       rd_mem,
    input  logic [2:0]       funct3_mem,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             valid_wb,
    output logic [CNT_W-1:0] retired_cnt
);

    // Writeback source encodings carried in control_word_mem[2:1].
    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_LOAD = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;

    // Load size/sign encodings from funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // WB-side state.
    logic             valid_r;
    logic             rf_wb_r;
    logic [1:0]       wb_src_r;
    logic             pc_src_r;
    logic [4:0]       rd_r;
    logic [2:0]       funct3_r;
    logic [XLEN-1:0]  mem_data_r;
    logic [XLEN-1:0]  alu_result_r;
    logic [XLEN-1:0]  pc_plus_4_r;
    logic [XLEN-1:0]  target_r;
    logic [CNT_W-1:0] retired_cnt_r;

    // Data registers load on a normal advance and also on flush; their
    // contents behind a bubble are never observed through the gated outputs.
    logic capture;
    assign capture = flush | ~stall;

    // Combinational load formatting and writeback select.
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [XLEN-1:0]  load_fmt;
    logic [XLEN-1:0]  wdata_sel;

    // Valid bit: flush beats stall, stall holds, otherwise follow MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (!stall) begin
            valid_r <= valid_mem;
        end
    end

    // Control fields of the WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wb_r  <= 1'b0;
            wb_src_r <= 2'b00;
            pc_src_r <= 1'b0;
            rd_r     <= 5'd0;
            funct3_r <= 3'b000;
        end else if (capture) begin
            rf_wb_r  <= control_word_mem[3];
            wb_src_r <= control_word_mem[2:1];
            pc_src_r <= control_word_mem[0];
            rd_r     <= rd_mem;
            funct3_r <= funct3_mem;
        end
    end

    // Datapath fields of the WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data_r   <= '0;
            alu_result_r <= '0;
            pc_plus_4_r  <= '0;
            target_r     <= '0;
        end else if (capture) begin
            mem_data_r   <= mem_data_out;
            alu_result_r <= alu_result_mem;
            pc_plus_4_r  <= pc_plus_4_mem;
            target_r     <= target_pc;
        end
    end

    // Retired counter: counts the WB instruction on the edge it leaves WB,
    // so a stalled instruction is counted once; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt_r <= '0;
        end else if (valid_r && !stall) begin
            retired_cnt_r <= retired_cnt_r + 1'b1;
        end
    end

    // Pick the addressed byte and halfword out of the raw memory word.
    always_comb begin
        load_byte = 8'h00;
        load_half = 16'h0000;
        case (alu_result_r[1:0])
            2'b00:   load_byte = mem_data_r[7:0];
            2'b01:   load_byte = mem_data_r[15:8];
            2'b10:   load_byte = mem_data_r[23:16];
            default: load_byte = mem_data_r[31:24];
        endcase
        if (alu_result_r[1]) begin
            load_half = mem_data_r[31:16];
        end else begin
            load_half = mem_data_r[15:0];
        end
    end

    // Extend the selected byte/half by funct3; unknown codes read the word.
    always_comb begin
        load_fmt = mem_data_r;
        case (funct3_r)
            F3_LB:   load_fmt = {{(XLEN-8){load_byte[7]}}, load_byte};
            F3_LBU:  load_fmt = {{(XLEN-8){1'b0}}, load_byte};
            F3_LH:   load_fmt = {{(XLEN-16){load_half[15]}}, load_half};
            F3_LHU:  load_fmt = {{(XLEN-16){1'b0}}, load_half};
            F3_LW:   load_fmt = mem_data_r;
            default: load_fmt = mem_data_r;
        endcase
    end

    // Writeback value select; the reserved encoding falls back to the ALU.
    always_comb begin
        wdata_sel = alu_result_r;
        case (wb_src_r)
            WB_SRC_ALU:  wdata_sel = alu_result_r;
            WB_SRC_LOAD: wdata_sel = load_fmt;
            WB_SRC_LINK: wdata_sel = pc_plus_4_r;
            default:     wdata_sel = alu_result_r;
        endcase
    end

    // Gated outputs; x0 suppression applies to the write port only.
    assign rf_we       = valid_r & rf_wb_r & (rd_r != 5'd0);
    assign rf_waddr    = rd_r;
    assign rf_wdata    = wdata_sel;
    assign pc_redirect = valid_r & pc_src_r;
    assign redirect_pc = target_r;
    assign valid_wb    = valid_r;
    assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expected values.

module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        valid_mem;
    logic        stall;
    logic        flush;
    logic [31:0] mem_data_out;
    logic [31:0] alu_result_mem;
    logic [31:0] pc_plus_4_mem;
    logic [31:0] target_pc;
    logic [3:0]  control_word_mem;
    logic [4:0]  rd_mem;
    logic [2:0]  funct3_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        valid_wb;
    logic [31:0] retired_cnt;

    int vec_count  = 0;
    int miscompares = 0;

    // Expected retire count and WB valid, stepped per applied edge.
    logic [31:0] exp_cnt   = 32'd0;
    logic        exp_valid = 1'b0;

    mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_mem        (valid_mem),
        .stall            (stall),
        .flush            (flush),
        .mem_data_out     (mem_data_out),
        .alu_result_mem   (alu_result_mem),
        .pc_plus_4_mem    (pc_plus_4_mem),
        .target_pc        (target_pc),
        .control_word_mem (control_word_mem),
        .rd_mem           (rd_mem),
        .funct3_mem       (funct3_mem),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .pc_redirect      (pc_redirect),
        .redirect_pc      (redirect_pc),
        .valid_wb         (valid_wb),
        .retired_cnt      (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one set of MEM inputs, advance the model, then clock and settle.
    task automatic applyStimulus(input logic v, input logic s, input logic f,
                                 input logic [3:0] ctrl, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [31:0] pc4,
                                 input logic [31:0] tgt);
        valid_mem        = v;
        stall            = s;
        flush            = f;
        control_word_mem = ctrl;
        rd_mem           = rd;
        funct3_mem       = f3;
        alu_result_mem   = alu;
        mem_data_out     = mem;
        pc_plus_4_mem    = pc4;
        target_pc        = tgt;
        if (exp_valid && !s) exp_cnt = exp_cnt + 32'd1;
        exp_valid = f ? 1'b0 : (s ? exp_valid : v);
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        valid_mem = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_data_out = '0; alu_result_mem = '0; pc_plus_4_mem = '0; target_pc = '0;
        control_word_mem = '0; rd_mem = '0; funct3_mem = '0;

        // Reset: outputs zero while rst is high.
        #12;
        checkOutput("rst_rf_we",       {31'd0, rf_we},       32'd0);
        checkOutput("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
        checkOutput("rst_valid_wb",    {31'd0, valid_wb},    32'd0);
        checkOutput("rst_rf_wdata",    rf_wdata,             32'd0);
        checkOutput("rst_cnt",         retired_cnt,          32'd0);
        rst = 1'b0;

        // Idle for 10 cycles: nothing retires.
        for (int i = 0; i < 10; i++) idleStep();
        checkOutput("idle_cnt",   retired_cnt,       32'd0);
        checkOutput("idle_valid", {31'd0, valid_wb}, 32'd0);

        // ALU writeback to x5.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 5'd5, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
        checkOutput("alu_rf_we",    {31'd0, rf_we},       32'd1);
        checkOutput("alu_waddr",    {27'd0, rf_waddr},    32'd5);
        checkOutput("alu_wdata",    rf_wdata,             32'h0000_1234);
        checkOutput("alu_redirect", {31'd0, pc_redirect}, 32'd0);
        checkOutput("alu_cnt0",     retired_cnt,          32'd0);
        idleStep();
        checkOutput("alu_cnt1",     retired_cnt,          32'd1);
        checkOutput("alu_valid_off",{31'd0, valid_wb},    32'd0);

        // Load formatting with mem word 0x80FF_7F01, ctrl = load writeback.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b000, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lb_off2",  rf_wdata, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b000, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lb_off0",  rf_wdata, 32'h0000_0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lbu_off3", rf_wdata, 32'h0000_0080);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b001, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lh_lo",    rf_wdata, 32'h0000_7F01);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b001, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lh_hi",    rf_wdata, 32'hFFFF_80FF);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b101, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lhu_hi",   rf_wdata, 32'h0000_80FF);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 5'd6, 3'b010, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0);
        checkOutput("lw",       rf_wdata, 32'h80FF_7F01);
        checkOutput("load_cnt", retired_cnt, exp_cnt);

        // Reserved wb_src encoding reads the ALU result.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1110, 5'd3, 3'b000, 32'h0000_0ABC, 32'h80FF_7F01, 32'h0000_0444, 32'h0);
        checkOutput("wbsrc11", rf_wdata, 32'h0000_0ABC);

        // JAL to x1: link value written, redirect issued.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1101, 5'd1, 3'b000, 32'h0000_0999, 32'h0, 32'h0000_0104, 32'h0000_0200);
        checkOutput("jal_wdata",    rf_wdata,             32'h0000_0104);
        checkOutput("jal_rf_we",    {31'd0, rf_we},       32'd1);
        checkOutput("jal_redirect", {31'd0, pc_redirect}, 32'd1);
        checkOutput("jal_rpc",      redirect_pc,          32'h0000_0200);

        // JAL to x0: write suppressed, redirect unaffected.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1101, 5'd0, 3'b000, 32'h0000_0999, 32'h0, 32'h0000_0104, 32'h0000_0200);
        checkOutput("jal0_rf_we",    {31'd0, rf_we},       32'd0);
        checkOutput("jal0_redirect", {31'd0, pc_redirect}, 32'd1);

        // Stall 3 cycles on a valid ALU instruction to x7.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 5'd7, 3'b000, 32'h0000_ABCD, 32'h0, 32'h0, 32'h0);
        checkOutput("pre_stall_cnt", retired_cnt, exp_cnt);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b1001, 5'd9, 3'b000, 32'h0000_5555, 32'h0, 32'h0, 32'h0000_0300);
            checkOutput("stall_wdata",    rf_wdata,             32'h0000_ABCD);
            checkOutput("stall_waddr",    {27'd0, rf_waddr},    32'd7);
            checkOutput("stall_redirect", {31'd0, pc_redirect}, 32'd0);
            checkOutput("stall_cnt",      retired_cnt,          exp_cnt);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 5'd8, 3'b000, 32'h0000_0011, 32'h0, 32'h0, 32'h0);
        checkOutput("post_stall_cnt",   retired_cnt,       exp_cnt);
        checkOutput("post_stall_waddr", {27'd0, rf_waddr}, 32'd8);

        // Stall and flush together: WB becomes a bubble, no retire.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1001, 5'd9, 3'b000, 32'h0000_2222, 32'h0, 32'h0, 32'h0000_0400);
        checkOutput("sf_valid",    {31'd0, valid_wb},    32'd0);
        checkOutput("sf_rf_we",    {31'd0, rf_we},       32'd0);
        checkOutput("sf_redirect", {31'd0, pc_redirect}, 32'd0);
        checkOutput("sf_cnt",      retired_cnt,          exp_cnt);

        // Async reset mid-redirect.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1101, 5'd1, 3'b000, 32'h0, 32'h0, 32'h0000_0504, 32'h0000_0800);
        checkOutput("pre_rst_redirect", {31'd0, pc_redirect}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_redirect", {31'd0, pc_redirect}, 32'd0);
        checkOutput("arst_rf_we",    {31'd0, rf_we},       32'd0);
        checkOutput("arst_cnt",      retired_cnt,          32'd0);
        exp_cnt   = 32'd0;
        exp_valid = 1'b0;
        #2;
        rst = 1'b0;
        idleStep();
        checkOutput("post_rst_cnt", retired_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
